bus_arbiter: RTL and testbench

Shares one downstream memory/MMU request port between the core's fetch and memory-access channels. Buffers single-cycle requests from each requester, grants them round-robin, keeps exactly one transaction outstanding downstream, and returns the response to the requester that owns it. It sits between the core's fetch/mem bus ports and the MMU/memory interconnect.

---
 rtl/bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one downstream request port between the fetch and
// memory-access channels. Each channel has a one-deep pending slot. Grants
// alternate round-robin, and only one transaction is outstanding at a time.

// One requester's pending slot. "valid" means waiting for a grant. "busy"
// means the requester owns a request that has not yet completed downstream.
module bus_arbiter_slot #(
  parameter int REQ_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_en,
  input  logic [REQ_W-1:0] req_in,
  input  logic             complete,
  input  logic             grant,
  output logic             cand,
  output logic [REQ_W-1:0] cand_req,
  output logic             drop
);
  logic             valid_q, busy_q, busy_eff, accept;
  logic [REQ_W-1:0] req_q;

  // The completing owner is free again in its own response cycle.
  assign busy_eff = busy_q & ~complete;
  assign accept   = req_en & ~busy_eff;
  assign drop     = req_en & busy_eff;
  // A request arriving this cycle can be granted directly, bypassing the slot.
  assign cand     = valid_q | accept;
  assign cand_req = valid_q ? req_q : req_in;

  // Slot bookkeeping: load on accept, leave pending on grant, free on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= (valid_q | accept) & ~grant;
      busy_q  <= busy_eff | accept;
      if (accept) req_q <= req_in;
    end
  end
endmodule

module bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_request_enable,
  input  logic                freq_mode,
  input  logic [ADDR_W-1:0]   freq_addr,
  input  logic [DATA_W-1:0]   freq_wdata,
  input  logic [DATA_W/8-1:0] freq_wstrb,
  output logic                fetch_response_enable,
  output logic [DATA_W-1:0]   fresp_data,
  input  logic                mem_request_enable,
  input  logic                mreq_mode,
  input  logic [ADDR_W-1:0]   mreq_addr,
  input  logic [DATA_W-1:0]   mreq_wdata,
  input  logic [DATA_W/8-1:0] mreq_wstrb,
  output logic                mem_response_enable,
  output logic [DATA_W-1:0]   mresp_data,
  output logic                bus_request_enable,
  output logic                breq_mode,
  output logic [ADDR_W-1:0]   breq_addr,
  output logic [DATA_W-1:0]   breq_wdata,
  output logic [DATA_W/8-1:0] breq_wstrb,
  input  logic                bus_response_enable,
  input  logic [DATA_W-1:0]   bresp_data,
  output logic                protocol_error
);
  localparam int STRB_W  = DATA_W / 8;
  localparam int NUM_REQ = 2;  // index 0 = fetch, 1 = mem

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic              mode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  state_t                    state_q, state_d;
  logic                      owner_q, last_grant_q, win, any_grant;
  req_t                      breq_q;
  req_t [NUM_REQ-1:0]        in_req, cand_req;
  logic [NUM_REQ-1:0]        req_en, cand, complete, grant, drop;

  assign req_en    = {mem_request_enable, fetch_request_enable};
  assign in_req[0] = {freq_mode, freq_addr, freq_wdata, freq_wstrb};
  assign in_req[1] = {mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    bus_arbiter_slot #(.REQ_W($bits(req_t))) u_slot (
      .clk      (clk),
      .rst      (rst),
      .req_en   (req_en[i]),
      .req_in   (in_req[i]),
      .complete (complete[i]),
      .grant    (grant[i]),
      .cand     (cand[i]),
      .cand_req (cand_req[i]),
      .drop     (drop[i])
    );
  end

  // Completion of the outstanding transaction, steered to its owner.
  assign complete = (state_q == WAIT && bus_response_enable)
                    ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

  // Grant point, round-robin pick, and next state.
  always_comb begin
    win       = 1'b0;
    any_grant = 1'b0;
    grant     = '0;
    state_d   = state_q;
    win       = (&cand) ? ~last_grant_q : cand[1];
    if (state_q == IDLE || bus_response_enable) any_grant = |cand;
    if (any_grant) grant = win ? 2'b10 : 2'b01;
    case (state_q)
      IDLE:    if (any_grant) state_d = WAIT;
      WAIT:    if (bus_response_enable) state_d = any_grant ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, downstream issue registers, response steering, and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= IDLE;
      owner_q               <= 1'b0;
      last_grant_q          <= 1'b0;
      breq_q                <= '0;
      bus_request_enable    <= 1'b0;
      fetch_response_enable <= 1'b0;
      mem_response_enable   <= 1'b0;
      fresp_data            <= '0;
      mresp_data            <= '0;
      protocol_error        <= 1'b0;
    end else begin
      state_q               <= state_d;
      bus_request_enable    <= any_grant;
      fetch_response_enable <= complete[0];
      mem_response_enable   <= complete[1];
      protocol_error        <= protocol_error | (|drop);
      if (any_grant) begin
        breq_q       <= cand_req[win];
        owner_q      <= win;
        last_grant_q <= win;
      end
      if (complete[0]) fresp_data <= bresp_data;
      if (complete[1]) mresp_data <= bresp_data;
    end
  end

  assign breq_mode  = breq_q.mode;
  assign breq_addr  = breq_q.addr;
  assign breq_wdata = breq_q.wdata;
  assign breq_wstrb = breq_q.wstrb;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter. Inputs change 1ns after a rising edge.
// Registered outputs are sampled at the same point, so each step() shows the
// result of the inputs sampled at that edge.
module tb_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_request_enable = 1'b0, freq_mode = 1'b0;
  logic [31:0] freq_addr = '0, freq_wdata = '0;
  logic [3:0]  freq_wstrb = '0;
  logic        mem_request_enable = 1'b0, mreq_mode = 1'b0;
  logic [31:0] mreq_addr = '0, mreq_wdata = '0;
  logic [3:0]  mreq_wstrb = '0;
  logic        bus_response_enable = 1'b0;
  logic [31:0] bresp_data = '0;
  logic        fetch_response_enable, mem_response_enable, bus_request_enable;
  logic        breq_mode, protocol_error;
  logic [31:0] fresp_data, mresp_data, breq_addr, breq_wdata;
  logic [3:0]  breq_wstrb;
  int          vecs = 0, errs = 0;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .fetch_request_enable(fetch_request_enable), .freq_mode(freq_mode),
    .freq_addr(freq_addr), .freq_wdata(freq_wdata), .freq_wstrb(freq_wstrb),
    .fetch_response_enable(fetch_response_enable), .fresp_data(fresp_data),
    .mem_request_enable(mem_request_enable), .mreq_mode(mreq_mode),
    .mreq_addr(mreq_addr), .mreq_wdata(mreq_wdata), .mreq_wstrb(mreq_wstrb),
    .mem_response_enable(mem_response_enable), .mresp_data(mresp_data),
    .bus_request_enable(bus_request_enable), .breq_mode(breq_mode),
    .breq_addr(breq_addr), .breq_wdata(breq_wdata), .breq_wstrb(breq_wstrb),
    .bus_response_enable(bus_response_enable), .bresp_data(bresp_data),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One-cycle request pulse on either or both channels.
  task automatic req(input logic f, input logic m, input logic [31:0] fa, input logic [31:0] ma);
    fetch_request_enable = f;
    mem_request_enable   = m;
    freq_addr            = fa;
    mreq_addr            = ma;
    step();
    fetch_request_enable = 1'b0;
    mem_request_enable   = 1'b0;
  endtask

  // One-cycle downstream response pulse.
  task automatic resp(input logic [31:0] d);
    bus_response_enable = 1'b1;
    bresp_data          = d;
    step();
    bus_response_enable = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    rst = 1'b0;
    chk("rst_breq_en", bus_request_enable, 0);
    chk("rst_fresp_en", fetch_response_enable, 0);
    chk("rst_mresp_en", mem_response_enable, 0);
    chk("rst_perr", protocol_error, 0);
    chk("rst_breq_addr", breq_addr, 0);
    chk("rst_fresp_data", fresp_data, 0);

    // Single fetch read
    req(1, 0, 32'h1000, 0);
    chk("f1_issue", bus_request_enable, 1);
    chk("f1_addr", breq_addr, 32'h1000);
    chk("f1_mode", breq_mode, 0);
    step();
    chk("f1_one_pulse", bus_request_enable, 0);
    step(); step(); step();
    resp(32'hDEADBEEF);
    chk("f1_resp_en", fetch_response_enable, 1);
    chk("f1_resp_data", fresp_data, 32'hDEADBEEF);
    chk("f1_no_mresp", mem_response_enable, 0);
    step();
    chk("f1_resp_width", fetch_response_enable, 0);
    chk("f1_resp_hold", fresp_data, 32'hDEADBEEF);

    // Simultaneous fetch read and mem write after reset: mem first
    rst = 1'b1; step(); rst = 1'b0;
    mreq_mode = 1'b1; mreq_wdata = 32'h55AA; mreq_wstrb = 4'hF;
    req(1, 1, 32'h2000, 32'h3000);
    mreq_mode = 1'b0; mreq_wdata = '0; mreq_wstrb = '0;
    chk("tie_issue", bus_request_enable, 1);
    chk("tie_addr_mem", breq_addr, 32'h3000);
    chk("tie_mode_mem", breq_mode, 1);
    chk("tie_wdata", breq_wdata, 32'h55AA);
    chk("tie_wstrb", breq_wstrb, 4'hF);
    step();
    chk("tie_hold_addr", breq_addr, 32'h3000);
    chk("tie_no_reissue", bus_request_enable, 0);
    resp(32'h12345678);
    chk("tie_mresp_en", mem_response_enable, 1);
    chk("tie_mresp_data", mresp_data, 32'h12345678);
    chk("tie_no_fresp", fetch_response_enable, 0);
    chk("tie_b2b_issue", bus_request_enable, 1);
    chk("tie_b2b_addr", breq_addr, 32'h2000);
    chk("tie_b2b_mode", breq_mode, 0);
    resp(32'hCAFEF00D);
    chk("tie_fresp_en", fetch_response_enable, 1);
    chk("tie_fresp_data", fresp_data, 32'hCAFEF00D);
    chk("tie_idle", bus_request_enable, 0);

    // Round robin: last grant fetch -> mem wins, then fetch
    req(1, 1, 32'h4000, 32'h5000);
    chk("rr1_mem", breq_addr, 32'h5000);
    resp(32'h1);
    chk("rr1_mresp", mem_response_enable, 1);
    chk("rr2_fetch", breq_addr, 32'h4000);
    chk("rr2_issue", bus_request_enable, 1);
    resp(32'h2);
    chk("rr2_fresp", fetch_response_enable, 1);
    // Lone mem grant makes mem the last winner, so the next tie goes to fetch
    req(0, 1, 0, 32'h6000);
    chk("rr3_mem", breq_addr, 32'h6000);
    resp(32'h3);
    chk("rr3_mresp", mem_response_enable, 1);
    req(1, 1, 32'h7000, 32'h7004);
    chk("rr4_fetch_wins", breq_addr, 32'h7000);
    resp(32'h4);
    chk("rr4_fresp_data", fresp_data, 32'h4);
    chk("rr5_mem", breq_addr, 32'h7004);
    resp(32'h5);
    chk("rr5_mresp_data", mresp_data, 32'h5);
    chk("rr_no_perr", protocol_error, 0);

    // Protocol violation: a second fetch request while the first is outstanding
    req(1, 0, 32'h8000, 0);
    chk("pe_issue", breq_addr, 32'h8000);
    step();
    req(1, 0, 32'h8800, 0);
    chk("pe_set", protocol_error, 1);
    chk("pe_no_issue", bus_request_enable, 0);
    chk("pe_addr_hold", breq_addr, 32'h8000);
    step();
    resp(32'hAAAA);
    chk("pe_first_done", fetch_response_enable, 1);
    chk("pe_first_data", fresp_data, 32'hAAAA);
    chk("pe_dropped", bus_request_enable, 0);
    step();
    chk("pe_dropped2", bus_request_enable, 0);
    chk("pe_sticky", protocol_error, 1);

    // Spurious downstream response in IDLE
    resp(32'hBBBB);
    chk("sp_no_fresp", fetch_response_enable, 0);
    chk("sp_no_mresp", mem_response_enable, 0);
    chk("sp_fdata_hold", fresp_data, 32'hAAAA);
    req(0, 1, 0, 32'h9000);
    chk("sp_issue", bus_request_enable, 1);
    chk("sp_addr", breq_addr, 32'h9000);

    // Reset while a mem transaction is outstanding
    rst = 1'b1; step(); rst = 1'b0;
    chk("mr_breq_en", bus_request_enable, 0);
    chk("mr_addr", breq_addr, 0);
    chk("mr_perr", protocol_error, 0);
    chk("mr_mdata", mresp_data, 0);
    resp(32'hCCCC);
    chk("mr_late_mresp", mem_response_enable, 0);
    chk("mr_late_fresp", fetch_response_enable, 0);
    req(0, 1, 0, 32'hA000);
    chk("mr_new_issue", bus_request_enable, 1);
    chk("mr_new_addr", breq_addr, 32'hA000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
